// File: rtl/uart_byte_tx.sv
// uart_byte_tx: FIFO-buffered 8N1 UART transmitter, LSB first.
// Ports:
//   sclk_50M  - clock
//   s_rst     - sync reset, active high
//   tx_data   - byte to send
//   tx_valid  - tx_data valid
//   tx_ready  - FIFO has room
//   tx        - serial line, idle high
//   busy      - a frame is on the line
//   done_flag - pulses on the last stop cycle
module uart_byte_tx #(
  parameter int BAUD_CNT   = 5208,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       sclk_50M,
  input  logic       s_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done_flag
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(BAUD_CNT + 1);

  localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(FIFO_DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(BAUD_CNT - 2);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic push;
  logic pop;
  logic nonempty;
  logic baud_end;
  logic [7:0] head;

  // Ready looks at count alone, so a full FIFO refuses a
  // write even on a cycle where the FSM pops.
  assign tx_ready = count < DEPTH;
  assign nonempty = count != '0;
  assign push     = tx_valid & tx_ready;
  assign baud_end = baud == BAUD_LAST;
  assign head     = mem[rd_ptr];

  // The FSM pops when idle, or at the very end of a stop bit
  // so the next start bit follows with no gap.
  assign pop = nonempty &
    ((state == IDLE) | ((state == STOP) & baud_end));

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  always_ff @(posedge sclk_50M) begin
    if (!s_rst && push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge sclk_50M) begin
    if (s_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sclk_50M) begin
    if (s_rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done_flag <= 1'b0;
      baud      <= '0;
      bit_idx   <= '0;
      shift     <= '0;
    end else begin
      done_flag <= 1'b0;
      unique case (state)
        IDLE: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          baud    <= '0;
          bit_idx <= '0;
          if (nonempty) begin
            shift <= head;
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            shift   <= shift >> 1;
            state   <= DATA;
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        STOP: begin
          // Registered pulse lands on the final stop cycle.
          if (baud == BAUD_PRE) done_flag <= 1'b1;
          if (baud_end) begin
            baud <= '0;
            if (nonempty) begin
              shift <= head;
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: bench for uart_byte_tx with a frame-level
// model, a serial line decoder and directed vectors.
module tb_uart_byte_tx;

  localparam int B = 56;
  localparam int D = 4;
  localparam int FR = 10 * B;

  logic       clk = 1'b0;
  logic       s_rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       done_flag;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  uart_byte_tx #(
    .BAUD_CNT(B),
    .FIFO_DEPTH(D)
  ) dut (
    .sclk_50M (clk),
    .s_rst    (s_rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy),
    .done_flag(done_flag)
  );

  always #10 clk = ~clk;

  // Frame-level model: a byte queue for the FIFO and a cycle
  // position inside the current 10-bit frame.
  logic [7:0] mq[$];
  bit         m_in  = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = '0;

  always @(posedge clk) begin : mdl
    int n;
    bit acc;
    if (s_rst) begin
      mq.delete();
      m_in  = 1'b0;
      m_pos = 0;
    end else begin
      n   = mq.size();
      acc = tx_valid && (n < D);
      if (m_in && m_pos == FR - 1) begin
        if (n > 0) begin
          m_cur = mq.pop_front();
          m_pos = 0;
        end else begin
          m_in = 1'b0;
        end
      end else if (m_in) begin
        m_pos++;
      end else if (n > 0) begin
        m_cur = mq.pop_front();
        m_in  = 1'b1;
        m_pos = 0;
      end
      if (acc) mq.push_back(tx_data);
    end
  end

  function automatic logic [3:0] m_exp();
    int  idx;
    logic t;
    t = 1'b1;
    if (m_in) begin
      idx = m_pos / B;
      if (idx == 0)      t = 1'b0;
      else if (idx <= 8) t = m_cur[idx-1];
      else               t = 1'b1;
    end
    return {t, m_in, m_in && (m_pos == FR - 1),
            mq.size() < D};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if ({tx, busy, done_flag, tx_ready} !== m_exp()) begin
        bad++;
        $display("FAIL model t=%0t got=%b exp=%b (tx,busy,done,rdy)",
                 $time, {tx, busy, done_flag, tx_ready}, m_exp());
      end
    end
  end

  // Serial decoder sampling mid-bit; aborts on reset.
  bit         rx_on  = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh  = '0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin : rxm
    int idx;
    if (s_rst === 1'b1) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % B == B / 2) begin
        idx = rx_cnt / B;
        if (idx >= 1 && idx <= 8) rx_sh[idx-1] = tx;
        if (idx == 9) begin
          if (tx === 1'b1) rx_q.push_back(rx_sh);
          rx_on = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int got,
                       input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  logic [9:0] lit55 = 10'b1010101010;
  logic [7:0] burst [4] = '{8'h55, 8'h12, 8'h34, 8'hAA};
  logic [5:0] rdy_seen;
  int dt [8];
  int dn, bcnt, c, viol;
  bit idle_seen;

  initial begin
    s_rst    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    tick(); tick(); tick();
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done_flag), 0);
    check("rst_ready", int'(tx_ready), 1);
    s_rst  = 1'b0;
    chk_en = 1'b1;
    tick();

    // Single 0x55
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    bcnt = 0;
    dn   = 0;
    for (int k = 1; k <= 600; k++) begin
      tick();
      if (busy) bcnt++;
      if (done_flag) begin
        dt[0] = k;
        dn++;
      end
      if ((k - 1) % B == B / 2 && (k - 1) / B < 10)
        check($sformatf("s55_bit%0d", (k - 1) / B),
              int'(tx), int'(lit55[(k - 1) / B]));
    end
    check("s55_busy_cycles", bcnt, 560);
    check("s55_done_count", dn, 1);
    check("s55_done_at", dt[0], 560);

    // Burst of four on consecutive edges
    rx_q.delete();
    bcnt = 0;
    dn   = 0;
    c    = 0;
    for (int i = 0; i < 4; i++) begin
      tx_data  = burst[i];
      tx_valid = 1'b1;
      tick();
      c++;
      if (busy) bcnt++;
    end
    tx_valid = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      c++;
      if (busy) bcnt++;
      if (done_flag) begin
        if (dn < 8) dt[dn] = c;
        dn++;
      end
      if (!busy) break;
    end
    check("burst_busy_cycles", bcnt, 2240);
    check("burst_done_count", dn, 4);
    check("burst_first_done", dt[0], 561);
    for (int i = 1; i < 4; i++)
      check($sformatf("burst_gap%0d", i), dt[i] - dt[i-1], 560);
    check("burst_rx_count", rx_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("burst_rx%0d", i),
            (rx_q.size() > i) ? int'(rx_q[i]) : -1,
            int'(burst[i]));

    // Six writes while idle: sixth dropped
    rx_q.delete();
    for (int i = 0; i < 6; i++) begin
      rdy_seen[i] = tx_ready;
      tx_data     = 8'(i + 1);
      tx_valid    = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    check("six_ready_seq", int'(rdy_seen), int'(6'b011111));
    check("six_ready_after", int'(tx_ready), 0);
    idle_seen = 1'b0;
    for (int k = 0; k < 3500; k++) begin
      tick();
      if (!busy) begin
        idle_seen = 1'b1;
        break;
      end
    end
    check("six_idle", int'(idle_seen), 1);
    check("six_rx_count", rx_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("six_rx%0d", i),
            (rx_q.size() > i) ? int'(rx_q[i]) : -1, i + 1);

    // Reset during data bit 3 of 0xAA with two queued
    rx_q.delete();
    c = 0;
    tx_data  = 8'hAA; tx_valid = 1'b1; tick(); c++;
    tx_data  = 8'h11; tick(); c++;
    tx_data  = 8'h22; tick(); c++;
    tx_valid = 1'b0;
    while (c < 246) begin
      tick();
      c++;
    end
    check("abort_pre_busy", int'(busy), 1);
    check("abort_pre_tx", int'(tx), 1);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    check("abort_tx", int'(tx), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(tx_ready), 1);
    check("abort_done", int'(done_flag), 0);
    viol = 0;
    for (int k = 0; k < 700; k++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || done_flag !== 1'b0)
        viol++;
    end
    check("abort_line_idle", viol, 0);
    check("abort_rx_count", rx_q.size(), 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_tx.md
UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 SHALL have parameter BAUD_CNT, default 5208, meaning clock cycles per bit (9600 baud at 50 MHz); benches override it to 56.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of bytes buffered; fixed power of two.
REQ-003 SHALL have port sclk_50M  input  1  system clock; all logic on its rising edge; one clock only.
REQ-004 SHALL have port s_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tx_data  input  8  byte to send.
REQ-006 SHALL have port tx_valid  input  1  tx_data is valid this cycle.
REQ-007 SHALL have port tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-009 SHALL have port busy  output  1  a frame is on the line.
REQ-010 SHALL have port done_flag  output  1  one-cycle pulse at frame end.

Function
REQ-011 SHALL accept a byte on any edge where tx_valid=1 and tx_ready=1 and s_rst=0; tx_valid with tx_ready=0 is ignored and the byte is dropped.
REQ-012 SHALL drive tx_ready=1 exactly when FIFO count < FIFO_DEPTH; ready depends on count only, so a pop in the same cycle does not allow a write while full.
REQ-013 SHALL leave the count unchanged on a simultaneous push and pop; pointers wrap modulo FIFO_DEPTH.
REQ-014 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: tx=1 and busy=0; if FIFO non-empty, SHALL pop the head byte into the shift register, set tx=0 and enter START on the same edge.
REQ-016 SHALL give a latency of one edge: a byte accepted at edge k into an empty FIFO while IDLE gives tx=0 from edge k+1.
REQ-017 SHALL hold each bit for exactly BAUD_CNT cycles using a baud counter 0..BAUD_CNT-1 that is cleared at every bit boundary.
REQ-018 SHALL send each frame as: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); 10*BAUD_CNT cycles in total.
REQ-019 SHALL count 0..7 in the DATA bit counter, then enter STOP.
REQ-020 SHALL pulse done_flag high for one cycle on the last cycle of the stop bit.
REQ-021 At the end of STOP, if the FIFO is non-empty, SHALL pop the next byte and drive the start bit on the next edge, with no idle gap between frames; otherwise SHALL return to IDLE.
REQ-022 SHALL hold busy=1 from the first start-bit cycle through the last stop-bit cycle, continuously across back-to-back frames.
REQ-023 SHALL not affect a frame in flight when tx_data or tx_valid change.

Reset
REQ-024 While s_rst=1 on an edge, SHALL set tx=1, busy=0, done_flag=0, FSM=IDLE, and clear all counters, FIFO pointers and the count; tx_ready=1 after reset.
REQ-025 On reset mid-frame, SHALL drive tx=1 from the next edge, discard the frame and the FIFO contents, and never issue a done_flag for the aborted frame.
REQ-026 SHALL ignore pushes while s_rst=1.

Verification (BAUD_CNT=56, 20 ns clock)
REQ-027 Single 0x55 -> tx low for 56 cycles, then 1,0,1,0,1,0,1,0 at 56 cycles each, then high for 56 cycles; done_flag pulses at cycle 560; busy high for exactly 560 cycles.
REQ-028 Burst 0x55,0x12,0x34,0xAA written on consecutive edges -> 4 contiguous frames of 2240 cycles with no idle gap; done_flag spaced 560 cycles apart.
REQ-029 Six consecutive writes while IDLE -> first 5 accepted (one already popped), tx_ready low after the 5th, 6th ignored until the first frame completes.
REQ-030 Assert s_rst during data bit 3 of 0xAA with 2 bytes queued -> tx=1 and busy=0 the next edge, tx_ready=1, no done_flag, line idle afterwards.
REQ-031 Loopback tx into the team's uart_rx (rx port) with burst 0x55,0x12,0x34,0xAA -> rx_data sequence 0x55,0x12,0x34,0xAA with 4 done_flag pulses from the receiver.
